// File: rtl/ntt_stream_core.sv
// ntt_stream_core
//   Walks a vector of cfg_len words: reads each word at src + i*STRIDE, applies
//   an element op (COPY, ADD mod Q, SUB mod Q, XOR with operand B) and writes
//   the result to dst + i*STRIDE through a req/gnt/valid memory port.
//   A read that sees no mem_valid for TIMEOUT cycles aborts the task with err.
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start, cfg_*      task request (taken only while ready) and its configuration
//   ready             idle, able to accept start
//   done              one-cycle pulse at task end (normal or aborted)
//   err               last task aborted on read timeout; cleared by the next accepted start
//   mem_req/we/addr/wdata, mem_gnt, mem_valid, mem_rdata   memory port
//   op_count          tasks completed since reset
//   word_count        words written in the current/last task
module ntt_stream_core #(
  parameter int CORE_ID = 0,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int LEN_W   = 16,
  parameter int STRIDE  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [1:0]        cfg_mode,
  input  logic [DATA_W-1:0] cfg_operand,
  input  logic [DATA_W-1:0] cfg_modulus,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [63:0]       op_count,
  output logic [LEN_W-1:0]  word_count
);

  // CORE_ID is only a tag for debug messages in simulation models.
  localparam int unused_core_id = CORE_ID;

  // tmo counts 0..TIMEOUT-1; reaching the last value without data aborts.
  localparam int                TMO_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] STRIDE_INC = ADDR_W'(STRIDE);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, COMPUTE, WR_REQ, ISSUE_RD} state_t;

  state_t            state_reg, state_next;
  logic              ready_reg, ready_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic              req_reg, req_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [63:0]       op_count_reg, op_count_next;
  logic [LEN_W-1:0]  word_count_reg, word_count_next;
  logic [LEN_W-1:0]  idx_reg, idx_next;
  // Running i*STRIDE, so no multiplier is needed for the address.
  logic [ADDR_W-1:0] offset_reg, offset_next;
  logic [TMO_W-1:0]  tmo_reg, tmo_next;
  logic [ADDR_W-1:0] src_reg, src_next;
  logic [ADDR_W-1:0] dst_reg, dst_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic [1:0]        mode_reg, mode_next;
  logic [DATA_W-1:0] operand_reg, operand_next;
  logic [DATA_W-1:0] modulus_reg, modulus_next;
  logic [DATA_W-1:0] a_reg, a_next;

  // Element op on the captured word A.
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] op_result;

  always_comb begin
    sum = {1'b0, a_reg} + {1'b0, operand_reg};
    if ((modulus_reg != '0) && (sum >= {1'b0, modulus_reg})) begin
      sum = sum - {1'b0, modulus_reg};
    end
    diff = a_reg - operand_reg;
    // With Q=0 this adds nothing, leaving the natural 2^DATA_W wrap.
    if (a_reg < operand_reg) begin
      diff = diff + modulus_reg;
    end
    case (mode_reg)
      2'd0:    op_result = a_reg;
      2'd1:    op_result = sum[DATA_W-1:0];
      2'd2:    op_result = diff;
      default: op_result = a_reg ^ operand_reg;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    ready_next      = ready_reg;
    done_next       = 1'b0;
    err_next        = err_reg;
    req_next        = req_reg;
    we_next         = we_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    op_count_next   = op_count_reg;
    word_count_next = word_count_reg;
    idx_next        = idx_reg;
    offset_next     = offset_reg;
    tmo_next        = tmo_reg;
    src_next        = src_reg;
    dst_next        = dst_reg;
    len_next        = len_reg;
    mode_next       = mode_reg;
    operand_next    = operand_reg;
    modulus_next    = modulus_reg;
    a_next          = a_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          src_next        = cfg_src;
          dst_next        = cfg_dst;
          len_next        = cfg_len;
          mode_next       = cfg_mode;
          operand_next    = cfg_operand;
          modulus_next    = cfg_modulus;
          err_next        = 1'b0;
          word_count_next = '0;
          idx_next        = '0;
          offset_next     = '0;
          if (cfg_len == '0) begin
            // Empty task: completes immediately without touching memory.
            done_next     = 1'b1;
            op_count_next = op_count_reg + 64'd1;
          end else begin
            ready_next = 1'b0;
            req_next   = 1'b1;
            we_next    = 1'b0;
            addr_next  = cfg_src;
            state_next = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        if (mem_gnt) begin
          req_next   = 1'b0;
          tmo_next   = '0;
          state_next = RD_DATA;
        end
      end
      RD_DATA: begin
        if (mem_valid) begin
          a_next     = mem_rdata;
          state_next = COMPUTE;
        end else if (tmo_reg == TMO_LAST) begin
          err_next      = 1'b1;
          done_next     = 1'b1;
          ready_next    = 1'b1;
          op_count_next = op_count_reg + 64'd1;
          state_next    = IDLE;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end
      COMPUTE: begin
        wdata_next = op_result;
        req_next   = 1'b1;
        we_next    = 1'b1;
        addr_next  = dst_reg + offset_reg;
        state_next = WR_REQ;
      end
      WR_REQ: begin
        if (mem_gnt) begin
          req_next        = 1'b0;
          word_count_next = word_count_reg + 1'b1;
          if (idx_reg == len_reg - 1'b1) begin
            done_next     = 1'b1;
            ready_next    = 1'b1;
            op_count_next = op_count_reg + 64'd1;
            state_next    = IDLE;
          end else begin
            idx_next    = idx_reg + 1'b1;
            offset_next = offset_reg + STRIDE_INC;
            state_next  = ISSUE_RD;
          end
        end
      end
      ISSUE_RD: begin
        // Separate state keeps mem_req low for a cycle between requests.
        req_next   = 1'b1;
        we_next    = 1'b0;
        addr_next  = src_reg + offset_reg;
        state_next = RD_REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      ready_reg      <= 1'b1;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      req_reg        <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      op_count_reg   <= '0;
      word_count_reg <= '0;
      idx_reg        <= '0;
      offset_reg     <= '0;
      tmo_reg        <= '0;
      src_reg        <= '0;
      dst_reg        <= '0;
      len_reg        <= '0;
      mode_reg       <= '0;
      operand_reg    <= '0;
      modulus_reg    <= '0;
      a_reg          <= '0;
    end else begin
      state_reg      <= state_next;
      ready_reg      <= ready_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
      req_reg        <= req_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      op_count_reg   <= op_count_next;
      word_count_reg <= word_count_next;
      idx_reg        <= idx_next;
      offset_reg     <= offset_next;
      tmo_reg        <= tmo_next;
      src_reg        <= src_next;
      dst_reg        <= dst_next;
      len_reg        <= len_next;
      mode_reg       <= mode_next;
      operand_reg    <= operand_next;
      modulus_reg    <= modulus_next;
      a_reg          <= a_next;
    end
  end

  assign ready      = ready_reg;
  assign done       = done_reg;
  assign err        = err_reg;
  assign mem_req    = req_reg;
  assign mem_we     = we_reg;
  assign mem_addr   = addr_reg;
  assign mem_wdata  = wdata_reg;
  assign op_count   = op_count_reg;
  assign word_count = word_count_reg;

endmodule

// File: tb/tb_ntt_stream_core.sv
// Bench for ntt_stream_core: a memory responder with configurable grant stalls
// and read latency, a transaction-level model of the expected reads/writes per
// task, and one per-cycle monitor comparing the memory port against it.
module tb_ntt_stream_core;
  localparam int TMO = 4;

  logic        clk, rst, start;
  logic [63:0] cfg_src, cfg_dst, cfg_operand, cfg_modulus;
  logic [15:0] cfg_len;
  logic [1:0]  cfg_mode;
  logic        ready, done, err, mem_req, mem_we, mem_gnt, mem_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata, op_count;
  logic [15:0] word_count;

  ntt_stream_core #(
    .CORE_ID(0), .DATA_W(64), .ADDR_W(64), .LEN_W(16), .STRIDE(8), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len), .cfg_mode(cfg_mode),
    .cfg_operand(cfg_operand), .cfg_modulus(cfg_modulus),
    .ready(ready), .done(done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .op_count(op_count), .word_count(word_count)
  );

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] data;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        log_q[$];
  logic [63:0] mem [logic [63:0]];
  logic [63:0] exp_ops = 0;
  int errors = 0, checks = 0, cyc = 0, done_cnt = 0, rd_count = 0;
  int max_stall = 0, max_vdelay = 1, withhold_idx = -1;
  bit block_writes = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  function automatic txn_t mk(input logic we, input logic [63:0] addr, input logic [63:0] data);
    txn_t t;
    t.we = we; t.addr = addr; t.data = data;
    return t;
  endfunction

  // Element op from the arithmetic definition, using wide integer modulo.
  function automatic logic [63:0] model_op(input logic [1:0] mode, input logic [63:0] a,
                                           input logic [63:0] b, input logic [63:0] q);
    logic [127:0] w;
    case (mode)
      2'd0: return a;
      2'd1: begin
        w = {64'h0, a} + {64'h0, b};
        if (q != 0) w = w % {64'h0, q};
        return w[63:0];
      end
      2'd2: begin
        if (q != 0) w = ({64'h0, a} + {64'h0, q} - {64'h0, b}) % {64'h0, q};
        else        w = {64'h0, a} - {64'h0, b};
        return w[63:0];
      end
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [63:0] rand_below_q();
    return {32'($urandom_range(32'hFFFF_FFFE, 0)), 32'($urandom())};
  endfunction

  // Memory responder: decides gnt at each falling edge for the coming rising edge.
  initial begin
    int stall_left;
    int vcnt;
    bit active;
    logic [63:0] vdata;
    stall_left = 0; vcnt = 0; active = 0; vdata = 0;
    mem_gnt = 0; mem_valid = 0; mem_rdata = 0;
    forever begin
      @(negedge clk);
      mem_gnt = 0;
      mem_valid = 0;
      if (rst) begin
        active = 0;
        vcnt = 0;
      end else begin
        if (vcnt > 0) begin
          vcnt--;
          if (vcnt == 0) begin
            mem_valid = 1;
            mem_rdata = vdata;
          end
        end
        if (mem_req && !(mem_we && block_writes)) begin
          if (!active) begin
            active = 1;
            stall_left = (max_stall == 0) ? 0 : int'($urandom_range(max_stall, 0));
          end
          if (stall_left == 0) begin
            mem_gnt = 1;
            active = 0;
            if (mem_we) begin
              mem[mem_addr] = mem_wdata;
            end else begin
              vdata = mem[mem_addr];
              // A withheld read answers far too late; the core must ignore it.
              if (rd_count == withhold_idx) vcnt = 10;
              else vcnt = (max_vdelay <= 1) ? 1 : int'($urandom_range(max_vdelay, 1));
              rd_count++;
            end
          end else begin
            stall_left--;
          end
        end
      end
    end
  end

  // Per-cycle compare: protocol stability plus every granted transaction.
  initial begin
    logic p_req, p_gnt, p_we;
    logic [63:0] p_addr, p_wdata;
    txn_t e;
    p_req = 0; p_gnt = 0; p_we = 0; p_addr = 0; p_wdata = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        p_req = 0;
        p_gnt = 0;
      end else begin
        if (p_req && !p_gnt) begin
          check("req_hold", 64'(mem_req), 64'd1);
          check("addr_hold", mem_addr, p_addr);
          check("we_hold", 64'(mem_we), 64'(p_we));
          if (p_we) check("wdata_hold", mem_wdata, p_wdata);
        end
        if (p_req && p_gnt) check("req_gap", 64'(mem_req), 64'd0);
        if (mem_req && mem_gnt) begin
          $display("txn cyc=%0d %s addr=0x%0h wdata=0x%0h", cyc, mem_we ? "WR" : "RD",
                   mem_addr, mem_we ? mem_wdata : 64'h0);
          log_q.push_back(mk(mem_we, mem_addr, mem_wdata));
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_txn: got we=%0b addr=0x%0h, want no transaction", mem_we, mem_addr);
          end else begin
            e = exp_q.pop_front();
            check("txn_we", 64'(mem_we), 64'(e.we));
            check("txn_addr", mem_addr, e.addr);
            if (e.we) check("txn_wdata", mem_wdata, e.data);
          end
        end
        if (done) done_cnt++;
        p_req = mem_req; p_gnt = mem_gnt; p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata;
      end
    end
  end

  // Builds the expected traffic, runs one task and checks its completion.
  // abort_at >= 0: that read times out; exp_cycles < 0: latency not checked.
  task automatic run_task(input string name, input logic [63:0] src, input logic [63:0] dst,
                          input int len, input logic [1:0] mode, input logic [63:0] b,
                          input logic [63:0] q, input int abort_at, input bit poke_busy,
                          input int exp_cycles);
    int nw, t0, dcyc, dc0;
    bit found;
    logic [63:0] a;
    exp_q.delete();
    log_q.delete();
    nw = 0;
    for (int i = 0; i < len; i++) begin
      a = mem[src + 64'(i) * 64'd8];
      exp_q.push_back(mk(1'b0, src + 64'(i) * 64'd8, 64'h0));
      if (i == abort_at) break;
      exp_q.push_back(mk(1'b1, dst + 64'(i) * 64'd8, model_op(mode, a, b, q)));
      nw++;
    end
    rd_count = 0;
    dc0 = done_cnt;
    @(negedge clk);
    cfg_src = src; cfg_dst = dst; cfg_len = 16'(len); cfg_mode = mode;
    cfg_operand = b; cfg_modulus = q; start = 1;
    t0 = cyc;
    found = 0;
    dcyc = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (n == 0) begin
        // Scramble the config: the running task must use the latched copy.
        start = 0;
        cfg_src = ~src; cfg_dst = ~dst; cfg_len = 16'(len + 3);
        cfg_mode = ~mode; cfg_operand = ~b; cfg_modulus = q + 64'd1;
      end
      if (poke_busy && n == 2) begin
        start = 1;
        cfg_len = 16'd0;
      end
      if (n == 3) start = 0;
      #2;
      if (done) begin
        found = 1;
        dcyc = cyc;
        break;
      end
    end
    start = 0;
    exp_ops++;
    check({name, ".done_seen"}, 64'(found), 64'd1);
    if (found) begin
      if (exp_cycles >= 0) check({name, ".latency"}, 64'(dcyc - t0), 64'(exp_cycles));
      check({name, ".op_count"}, op_count, exp_ops);
      if (len > 0) check({name, ".word_count"}, 64'(word_count), 64'(nw));
      check({name, ".err"}, 64'(err), (abort_at >= 0) ? 64'd1 : 64'd0);
      check({name, ".ready"}, 64'(ready), 64'd1);
      check({name, ".txn_left"}, 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      #2;
      check({name, ".done_pulse"}, 64'(done), 64'd0);
      check({name, ".done_count"}, 64'(done_cnt - dc0), 64'd1);
    end
    $display("task %s len=%0d finished", name, len);
  endtask

  initial begin
    bit found;
    int dc;
    logic [63:0] q_g, b_r;
    rst = 1; start = 0;
    cfg_src = 0; cfg_dst = 0; cfg_len = 0; cfg_mode = 0; cfg_operand = 0; cfg_modulus = 0;
    repeat (3) @(negedge clk);
    #2;
    check("rst.ready", 64'(ready), 64'd1);
    check("rst.done", 64'(done), 64'd0);
    check("rst.err", 64'(err), 64'd0);
    check("rst.mem_req", 64'(mem_req), 64'd0);
    check("rst.mem_we", 64'(mem_we), 64'd0);
    check("rst.mem_addr", mem_addr, 64'd0);
    check("rst.mem_wdata", mem_wdata, 64'd0);
    check("rst.op_count", op_count, 64'd0);
    check("rst.word_count", 64'(word_count), 64'd0);
    rst = 0;

    // 1: COPY, zero-wait, 5 cycles per word.
    for (int i = 0; i < 4; i++) mem[64'h100 + 64'(i) * 64'd8] = 64'hA5A5_0000_0000_0000 | 64'(i + 1);
    run_task("copy4", 64'h100, 64'h200, 4, 2'd0, 64'h0, 64'h0, -1, 1'b0, 20);
    check("copy4.log_size", 64'(log_q.size()), 64'd8);
    if (log_q.size() == 8) begin
      check("copy4.rd0_addr", log_q[0].addr, 64'h100);
      check("copy4.wr0_addr", log_q[1].addr, 64'h200);
      check("copy4.wr0_data", log_q[1].data, 64'hA5A5_0000_0000_0001);
      check("copy4.rd3_addr", log_q[6].addr, 64'h118);
      check("copy4.wr3_addr", log_q[7].addr, 64'h218);
      check("copy4.wr3_data", log_q[7].data, 64'hA5A5_0000_0000_0004);
    end
    check("copy4.op_count_lit", op_count, 64'd1);
    check("copy4.word_count_lit", 64'(word_count), 64'd4);

    // 2: ADD and SUB modulo 17.
    mem[64'h300] = 64'd14; mem[64'h308] = 64'd3;
    run_task("add17", 64'h300, 64'h380, 2, 2'd1, 64'd5, 64'd17, -1, 1'b0, 10);
    if (log_q.size() == 4) begin
      check("add17.w0", log_q[1].data, 64'd2);
      check("add17.w1", log_q[3].data, 64'd8);
    end
    mem[64'h400] = 64'd3; mem[64'h408] = 64'd16;
    run_task("sub17", 64'h400, 64'h500, 2, 2'd2, 64'd5, 64'd17, -1, 1'b0, 10);
    if (log_q.size() == 4) begin
      check("sub17.w0", log_q[1].data, 64'd15);
      check("sub17.w1", log_q[3].data, 64'd11);
    end

    // 3: ADD with Q=0 wraps; XOR.
    mem[64'h600] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_task("add_q0", 64'h600, 64'h700, 1, 2'd1, 64'd2, 64'd0, -1, 1'b0, 5);
    if (log_q.size() == 2) check("add_q0.w0", log_q[1].data, 64'h1);
    mem[64'h608] = 64'h0F;
    run_task("xor", 64'h608, 64'h708, 1, 2'd3, 64'hFF, 64'd0, -1, 1'b0, 5);
    if (log_q.size() == 2) check("xor.w0", log_q[1].data, 64'hF0);

    // 4: random grant stalls and read latencies up to the timeout edge.
    max_stall = 7;
    max_vdelay = TMO;
    q_g = 64'hFFFF_FFFF_0000_0001;
    for (int i = 0; i < 8; i++) mem[64'h1000 + 64'(i) * 64'd8] = rand_below_q();
    b_r = rand_below_q();
    run_task("add_stall", 64'h1000, 64'h2000, 8, 2'd1, b_r, q_g, -1, 1'b0, -1);
    b_r = rand_below_q();
    run_task("sub_stall", 64'h1000, 64'h3000, 8, 2'd2, b_r, q_g, -1, 1'b0, -1);
    max_stall = 0;
    max_vdelay = 1;

    // 5: read of word 2 never answered in time: abort TMO cycles after RD_DATA entry.
    for (int i = 0; i < 4; i++) mem[64'h800 + 64'(i) * 64'd8] = 64'h5000 + 64'(i);
    withhold_idx = 2;
    run_task("timeout", 64'h800, 64'h900, 4, 2'd0, 64'h0, 64'h0, 2, 1'b0, 5 * 2 + 2 + TMO);
    dc = done_cnt;
    repeat (20) @(negedge clk);
    #2;
    check("timeout.late_ready", 64'(ready), 64'd1);
    check("timeout.late_err", 64'(err), 64'd1);
    check("timeout.late_done", 64'(done_cnt - dc), 64'd0);
    check("timeout.late_words", 64'(word_count), 64'd2);
    withhold_idx = -1;
    run_task("after_abort", 64'h800, 64'h900, 1, 2'd0, 64'h0, 64'h0, -1, 1'b0, 5);

    // 6: reset while a write is waiting for its grant.
    exp_q.delete();
    log_q.delete();
    rd_count = 0;
    mem[64'hE00] = 64'h77;
    exp_q.push_back(mk(1'b0, 64'hE00, 64'h0));
    block_writes = 1;
    @(negedge clk);
    cfg_src = 64'hE00; cfg_dst = 64'hF00; cfg_len = 16'd2; cfg_mode = 2'd0; start = 1;
    found = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      start = 0;
      #2;
      if (mem_req && mem_we) begin
        found = 1;
        break;
      end
    end
    check("rst_mid.reach_wr", 64'(found), 64'd1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    exp_ops = 0;
    block_writes = 0;
    #2;
    check("rst_mid.mem_req", 64'(mem_req), 64'd0);
    check("rst_mid.ready", 64'(ready), 64'd1);
    check("rst_mid.op_count", op_count, 64'd0);
    check("rst_mid.word_count", 64'(word_count), 64'd0);
    check("rst_mid.done", 64'(done), 64'd0);
    check("rst_mid.txn_left", 64'(exp_q.size()), 64'd0);

    mem[64'hA00] = 64'h1234;
    run_task("busy_poke", 64'hA00, 64'hB00, 1, 2'd3, 64'h1, 64'h0, -1, 1'b1, 5);
    if (log_q.size() == 2) check("busy_poke.w0", log_q[1].data, 64'h1235);
    run_task("len0", 64'hC00, 64'hD00, 0, 2'd0, 64'h0, 64'h0, -1, 1'b0, 1);
    check("len0.op_count_lit", op_count, 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
